pll_lock_guard: RTL and testbench

Sits directly downstream of the PLL reconfiguration sequencer and the reconfigurable core PLL. It consumes the sequencer's "config running" flag and the PLL's asynchronous locked signal. It holds the core in reset during reconfiguration and until lock is stable. It also pulses the PLL areset on lock timeout with bounded retries, and flags a sticky failure when the retries are exhausted.

---
 rtl/pll_pkg.sv | 32 +++
 rtl/pll_lock_guard_if.sv | 21 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_guard.sv | 126 ++++++++++++
 tb/tb_pll_lock_guard.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL reconfiguration slice: guard FSM states,
// default guard timings and the reconfig register map used by the sequencer.
package pll_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RUN       = 3'd2,
    ST_CFG       = 3'd3,
    ST_ARESET    = 3'd4,
    ST_FAIL      = 3'd5
  } pll_guard_state_t;

  localparam int PLL_STABLE_CYCLES_DEF  = 1024;
  localparam int PLL_TIMEOUT_CYCLES_DEF = 1048576;
  localparam int PLL_ARESET_CYCLES_DEF  = 16;
  localparam int PLL_MAX_RETRIES_DEF    = 3;
  localparam int PLL_CNT_W_DEF          = 21;

  // Reconfig register addresses driven by the sequencer.
  localparam logic [5:0] RCFG_ADDR_MODE   = 6'h00;
  localparam logic [5:0] RCFG_ADDR_STATUS = 6'h01;
  localparam logic [5:0] RCFG_ADDR_START  = 6'h02;
  localparam logic [5:0] RCFG_ADDR_N_CNT  = 6'h03;
  localparam logic [5:0] RCFG_ADDR_M_CNT  = 6'h04;
  localparam logic [5:0] RCFG_ADDR_C_CNT  = 6'h05;

  function automatic logic [2:0] retry_inc(input logic [2:0] r);
    return (r == 3'd7) ? 3'd7 : r + 3'd1;
  endfunction

endpackage

// File: rtl/pll_lock_guard_if.sv
// Guard-side bundle: sequencer/PLL status in, core/PLL control and debug out.
// All signals are level-sensitive; there is no valid/ready handshake on this bundle.
interface pll_lock_guard_if;
  logic       cfg_running;
  logic       pll_locked;
  logic       core_reset;
  logic       pll_areset;
  logic       lock_fail;
  logic [2:0] retry_count;
  logic [2:0] state_dbg;

  modport master (
    input  cfg_running, pll_locked,
    output core_reset, pll_areset, lock_fail, retry_count, state_dbg
  );

  modport slave (
    output cfg_running, pll_locked,
    input  core_reset, pll_areset, lock_fail, retry_count, state_dbg
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to zero.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/pll_lock_guard.sv
// Holds the core in reset through PLL reconfiguration and until lock is stable;
// retries PLL areset on lock timeout and latches a failure once retries run out.
module pll_lock_guard
  import pll_pkg::*;
#(
  parameter int STABLE_CYCLES  = PLL_STABLE_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = PLL_TIMEOUT_CYCLES_DEF,
  parameter int ARESET_CYCLES  = PLL_ARESET_CYCLES_DEF,
  parameter int MAX_RETRIES    = PLL_MAX_RETRIES_DEF,
  parameter int CNT_W          = PLL_CNT_W_DEF
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  pll_lock_guard_if.master bus
);

  pll_guard_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       retry_q, retry_d;
  logic             core_reset_q, pll_areset_q, lock_fail_q;
  logic             locked_s;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk_sys),
    .rst_n (reset_n),
    .d     (bus.pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    // Reconfiguration pre-empts everything, including a timeout in the same cycle.
    if (bus.cfg_running && state_q != ST_CFG) begin
      state_d = ST_CFG;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            cnt_d = '0;
            if (retry_q < 3'(MAX_RETRIES)) begin
              state_d = ST_ARESET;
              retry_d = retry_inc(retry_q);
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STABLE: begin
          // Loss of lock takes precedence over reaching the stable count.
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_CFG: begin
          if (!bus.cfg_running) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_ARESET: begin
          if (cnt_q == CNT_W'(ARESET_CYCLES - 1)) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move on the entering edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_WAIT_LOCK;
      cnt_q        <= '0;
      retry_q      <= '0;
      core_reset_q <= 1'b1;
      pll_areset_q <= 1'b0;
      lock_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      core_reset_q <= (state_d != ST_RUN);
      pll_areset_q <= (state_d == ST_ARESET);
      lock_fail_q  <= (state_d == ST_FAIL);
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.pll_areset  = pll_areset_q;
  assign bus.lock_fail   = lock_fail_q;
  assign bus.retry_count = retry_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_pll_lock_guard.sv
// Randomised and directed bench for pll_lock_guard against a countdown-based reference model.
module tb_pll_lock_guard;
  localparam int S = 8;
  localparam int T = 64;
  localparam int A = 4;
  localparam int R = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  pll_lock_guard_if bus_if ();

  pll_lock_guard #(
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T),
    .ARESET_CYCLES  (A),
    .MAX_RETRIES    (R),
    .CNT_W          (21)
  ) dut (
    .clk_sys (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Modes carry the debug codes the guard reports; timers count down to expiry.
  typedef enum int {M_WAIT = 0, M_QUAL = 1, M_RUN = 2, M_CFG = 3, M_PULSE = 4, M_DEAD = 5} mode_t;
  mode_t m_mode;
  int    m_left;
  int    m_retry;
  bit    m_sync[$];

  function automatic void model_reset();
    m_mode  = M_WAIT;
    m_left  = T;
    m_retry = 0;
    m_sync.delete();
    m_sync.push_back(1'b0);
    m_sync.push_back(1'b0);
  endfunction

  function automatic void model_step(input bit cfg, input bit lock);
    bit ls;
    ls = m_sync[0];
    void'(m_sync.pop_front());
    m_sync.push_back(lock);
    if (cfg && m_mode != M_CFG) begin
      m_mode  = M_CFG;
      m_retry = 0;
      return;
    end
    case (m_mode)
      M_WAIT: begin
        if (ls) begin m_mode = M_QUAL; m_left = S; end
        else if (m_left == 1) begin
          if (m_retry < R) begin
            m_mode = M_PULSE; m_left = A;
            m_retry = (m_retry < 7) ? m_retry + 1 : 7;
          end else m_mode = M_DEAD;
        end else m_left--;
      end
      M_QUAL: begin
        if (!ls) begin m_mode = M_WAIT; m_left = T; end
        else if (m_left == 1) begin m_mode = M_RUN; m_retry = 0; end
        else m_left--;
      end
      M_RUN:   if (!ls) begin m_mode = M_WAIT; m_left = T; end
      M_CFG:   if (!cfg) begin m_mode = M_WAIT; m_left = T; end
      M_PULSE: begin
        if (m_left == 1) begin m_mode = M_WAIT; m_left = T; end
        else m_left--;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [8:0] model_vec();
    return {m_mode != M_RUN, m_mode == M_PULSE, m_mode == M_DEAD, 3'(m_retry), 3'(m_mode)};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {bus_if.core_reset, bus_if.pll_areset, bus_if.lock_fail, bus_if.retry_count, bus_if.state_dbg};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge: drive, advance model over the next rising edge, compare.
  task automatic step(input bit cfg, input bit lock);
    bus_if.cfg_running = cfg;
    bus_if.pll_locked  = lock;
    model_step(cfg, lock);
    @(negedge clk);
    check("cycle", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus_if.cfg_running = 1'b0;
    bus_if.pll_locked  = 1'b0;
    model_reset();
    #1;
    check("rst_core_reset", 32'(bus_if.core_reset), 32'd1);
    check("rst_pll_areset", 32'(bus_if.pll_areset), 32'd0);
    check("rst_lock_fail", 32'(bus_if.lock_fail), 32'd0);
    check("rst_retry", 32'(bus_if.retry_count), 32'd0);
    check("rst_state", 32'(bus_if.state_dbg), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int t_rel, t_a1, t_a2, t_fail;
    bit prev_ar;
    bus_if.cfg_running = 1'b0;
    bus_if.pll_locked  = 1'b0;

    // Release with lock already present: core reset drops after sync + entry + stable count.
    do_reset();
    t_rel = -1;
    for (int i = 1; i <= 30; i++) begin
      step(1'b0, 1'b1);
      if (t_rel < 0 && bus_if.core_reset == 1'b0) t_rel = i;
    end
    check("release_lat", 32'(t_rel), 32'(2 + 1 + S));

    // One-cycle lock glitch in RUN, then recovery.
    step(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);

    // Reconfiguration for 20 cycles while locked.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);

    // Timeout coinciding with cfg_running: CFG wins, no retry counted.
    do_reset();
    for (int i = 0; i < T - 1; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("cfg_vs_timeout", 32'({bus_if.retry_count, bus_if.state_dbg}), 32'({3'd0, 3'd3}));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // No lock at all: two areset pulses, then sticky failure.
    do_reset();
    t_a1 = -1; t_a2 = -1; t_fail = -1; prev_ar = 1'b0;
    for (int i = 1; i <= 3 * T + 2 * A + 12; i++) begin
      step(1'b0, 1'b0);
      if (bus_if.pll_areset && !prev_ar) begin
        if (t_a1 < 0) t_a1 = i; else if (t_a2 < 0) t_a2 = i;
      end
      if (t_fail < 0 && bus_if.lock_fail) t_fail = i;
      prev_ar = bus_if.pll_areset;
    end
    check("areset1_time", 32'(t_a1), 32'(T));
    check("areset2_time", 32'(t_a2), 32'(2 * T + A));
    check("fail_time", 32'(t_fail), 32'(3 * T + 2 * A));
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);

    // Leave FAIL through reconfiguration.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1);

    // Random lock levels and sparse cfg pulses.
    for (int seg = 0; seg < 30; seg++) begin
      bit lvl;
      int len;
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 90);
      for (int i = 0; i < len; i++) step($urandom_range(0, 99) < 3, lvl);
    end

    // Asynchronous reset in the middle of an areset pulse.
    do_reset();
    t_a1 = -1;
    for (int i = 1; i <= T + 4 && t_a1 < 0; i++) begin
      step(1'b0, 1'b0);
      if (bus_if.pll_areset) t_a1 = i;
    end
    check("areset_seen", 32'(t_a1), 32'(T));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_areset", 32'(bus_if.pll_areset), 32'd0);
    check("async_core_reset", 32'(bus_if.core_reset), 32'd1);
    check("async_state", 32'(bus_if.state_dbg), 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
